rr_stream_mux: RTL

Parametrised N:1 streaming multiplexer with per-input valid/ready handshakes, round-robin or fixed-priority arbitration, and packet locking. It accepts one beat from a selected input and registers it into a single output stage. This is the sequential successor to the combinational select mux. It sits between multiple producers and one shared downstream consumer, for example a shared bus or FIFO write port.

---
 rtl/rr_mux_pkg.sv | 14 +
 rtl/rr_pick.sv | 58 +++++
 rtl/rr_stream_mux.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin stream mux: arbitration mode codes and FSM states.
// Latency: not applicable (constants and types only).
// Backpressure: not applicable.
package rr_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;  // input 0 always has highest priority
   localparam logic MODE_RR    = 1'b1;  // rotate priority after each completed packet

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational N-way picker: fixed-priority or round-robin from a start pointer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller gates the grant with its own stage-advance condition.
//
// Ports:
//   req_i  - request vector, one bit per input
//   ptr_i  - round-robin start index (ignored in fixed mode)
//   mode_i - MODE_FIXED or MODE_RR
//   gnt_o  - one-hot grant (all zero when nothing requests)
//   idx_o  - encoded index of the granted input
//   vld_o  - a grant exists
module rr_pick
   import rr_mux_pkg::*;
#(
   parameter int NUM_INPUTS = 8,
   parameter int SEL_WIDTH  = 3
) (
   input  logic [NUM_INPUTS-1:0] req_i,
   input  logic [SEL_WIDTH-1:0]  ptr_i,
   input  logic                  mode_i,
   output logic [NUM_INPUTS-1:0] gnt_o,
   output logic [SEL_WIDTH-1:0]  idx_o,
   output logic                  vld_o
);

   logic [NUM_INPUTS-1:0]   masked;
   logic [2*NUM_INPUTS-1:0] dbl;

   // Lower half keeps only requests at or above the pointer; upper half is the
   // full vector, so scanning upward from bit 0 wraps naturally past N-1.
   // Fixed mode leaves the mask open, which makes the lower half win from 0.
   always_comb begin
      masked = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         masked[i] = req_i[i] && ((mode_i == MODE_FIXED) || (i >= int'(ptr_i)));
      end
   end

   assign dbl = {req_i, masked};

   always_comb begin
      logic found;
      found = 1'b0;
      idx_o = '0;
      gnt_o = '0;
      for (int i = 0; i < 2*NUM_INPUTS; i++) begin
         if (!found && dbl[i]) begin
            found = 1'b1;
            idx_o = SEL_WIDTH'(i % NUM_INPUTS);
         end
      end
      if (found) begin
         gnt_o[idx_o] = 1'b1;
      end
      vld_o = found;
   end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 stream mux with round-robin/fixed arbitration, packet locking and one output register.
// Latency: 1 cycle from accepted input beat to out_valid; 1 beat/cycle sustained.
// Backpressure: out_valid && !out_ready freezes the output stage, FSM and pointer; all in_ready low.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_last    - per-input beat valid and end-of-packet
//   in_data             - flattened data, input i at [i*WIDTH +: WIDTH]
//   in_ready            - per-input accept, at most one bit high
//   force_en/force_sel  - override arbitration with a fixed index between packets
//   out_valid/out_last/out_data/out_src/out_ready - registered output stream
module rr_stream_mux
   import rr_mux_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int NUM_INPUTS = 8,
   parameter int SEL_WIDTH  = 3,
   parameter int MODE       = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_INPUTS-1:0]       in_valid,
   input  logic [NUM_INPUTS-1:0]       in_last,
   input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
   output logic [NUM_INPUTS-1:0]       in_ready,
   input  logic                        force_en,
   input  logic [SEL_WIDTH-1:0]        force_sel,
   output logic                        out_valid,
   output logic                        out_last,
   output logic [WIDTH-1:0]            out_data,
   output logic [SEL_WIDTH-1:0]        out_src,
   input  logic                        out_ready
);

   localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(NUM_INPUTS - 1);
   localparam logic                 PICK_MODE = (MODE == 0) ? MODE_FIXED : MODE_RR;

   state_t               state_q, state_d;
   logic [SEL_WIDTH-1:0] lock_q, lock_d;
   logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
   logic [SEL_WIDTH-1:0] src_q, src_d;
   logic                 vld_q, vld_d;
   logic                 last_q, last_d;
   logic [WIDTH-1:0]     data_q, data_d;

   logic                  adv;
   logic                  xfer;
   logic [NUM_INPUTS-1:0] req;
   logic [NUM_INPUTS-1:0] gnt;
   logic [SEL_WIDTH-1:0]  gidx;
   logic                  gvld;

   assign adv = !vld_q || out_ready;

   // Candidate set: the locked input mid-packet, otherwise the forced index
   // (an out-of-range force_sel matches nothing), otherwise every valid input.
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (state_q == LOCKED) begin
            req[i] = in_valid[i] && (SEL_WIDTH'(i) == lock_q);
         end else if (force_en) begin
            req[i] = in_valid[i] && (SEL_WIDTH'(i) == force_sel);
         end else begin
            req[i] = in_valid[i];
         end
      end
   end

   rr_pick #(
      .NUM_INPUTS (NUM_INPUTS),
      .SEL_WIDTH  (SEL_WIDTH)
   ) u_pick (
      .req_i  (req),
      .ptr_i  (ptr_q),
      .mode_i (PICK_MODE),
      .gnt_o  (gnt),
      .idx_o  (gidx),
      .vld_o  (gvld)
   );

   assign xfer     = adv && gvld && !reset;
   assign in_ready = (adv && !reset) ? gnt : '0;

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      ptr_d   = ptr_q;
      vld_d   = vld_q;
      last_d  = last_q;
      data_d  = data_q;
      src_d   = src_q;
      if (xfer) begin
         vld_d  = 1'b1;
         data_d = in_data[gidx*WIDTH +: WIDTH];
         last_d = in_last[gidx];
         src_d  = gidx;
         if (in_last[gidx]) begin
            state_d = IDLE;
            // Pointer only moves on packet boundaries so a packet is never split.
            if (PICK_MODE == MODE_RR) begin
               ptr_d = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
            end
         end else begin
            state_d = LOCKED;
            lock_d  = gidx;
         end
      end else if (adv) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         lock_q  <= '0;
         ptr_q   <= '0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         ptr_q   <= ptr_d;
         vld_q   <= vld_d;
         last_q  <= last_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

   assign out_valid = vld_q;
   assign out_last  = last_q;
   assign out_data  = data_q;
   assign out_src   = src_q;

endmodule
